key_event_ctrl: RTL
===================

Name: key_event_ctrl

Overview:
- Upstream input stage for the clock/display core: debounces the board push-buttons and converts them into clean, single-cycle key events.
- Events: press, short release, long-press, auto-repeat. The time-keeping logic consumes these instead of raw or edge-sensitive key levels.
- Single clock domain, 50 MHz system clock. The timebase is derived internally, so downstream logic never clocks on data signals.

Parameters:
- NKEY, 2, number of keys handled, one independent channel each.
- TICK_DIV, 131072, clk cycles per sampling tick (about 2.6 ms at 50 MHz).
- DEB_SAMPLES, 3, consecutive identical tick samples needed to change the debounced level; must be >= 2.
- LONG_TICKS, 384, ticks of continuous press before key_long (about 1 s); must be >= 1.
- REPEAT_TICKS, 77, ticks between key_repeat pulses once long-press is confirmed (about 200 ms); must be >= 1.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- key_in  input  NKEY  raw buttons, active-low (0 = pressed), asynchronous to clk
- key_down  output  NKEY  debounced level, 1 = pressed
- key_press  output  NKEY  1-cycle pulse on debounced press
- key_short  output  NKEY  1-cycle pulse on release before long-press was confirmed
- key_long  output  NKEY  1-cycle pulse when the press reaches LONG_TICKS
- key_repeat  output  NKEY  1-cycle pulse every REPEAT_TICKS while held after key_long
- tick  output  1  1-cycle sampling-tick strobe, exported for reuse

Behaviour:
- Reset:
  - Async clear, one clock domain.
  - All outputs 0.
  - Synchronizers and debounce shift registers all ones (released).
  - Tick counter 0. Channel FSMs IDLE. Hold and repeat counters 0.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick is high for exactly the one cycle when the counter equals TICK_DIV-1.
- Synchronizer: key_in passes through 2 flops per bit before any use.
- Debounce, per key, on tick only:
  - Shift the synchronized bit into a DEB_SAMPLES-wide register.
  - All zeros → debounced level pressed. All ones → released. Mixed → hold the previous level.
  - key_down and the edge pulses are registered. They update on the clk edge following the deciding tick.
- Latency: a clean press held from cycle 0 produces key_down within DEB_SAMPLES*TICK_DIV+3 cycles, and never earlier than (DEB_SAMPLES-1)*TICK_DIV cycles.
- Channel FSM, states IDLE, PRESSED, HELD:
  - IDLE → PRESSED on debounced press. Assert key_press, clear the hold counter.
  - In PRESSED, each tick increments the hold counter.
  - On the tick where the counter reaches LONG_TICKS, go to HELD. Assert key_long, clear the repeat counter.
  - PRESSED → IDLE on debounced release. Assert key_short.
  - In HELD, each tick increments the repeat counter. When it reaches REPEAT_TICKS, assert key_repeat and clear it to 0. This repeats indefinitely.
  - HELD → IDLE on debounced release. No short pulse.
- Pulse timing:
  - key_press coincides with the first cycle key_down=1.
  - key_short coincides with the first cycle key_down=0.
  - At most one of key_press/key_short/key_long/key_repeat per key per cycle.
- Simultaneous events:
  - If release is decided on the same tick the hold counter would reach LONG_TICKS, release wins: key_short, no key_long.
  - Release in HELD on a tick where a repeat is due: no key_repeat.
- Width rules:
  - The hold counter is clog2(LONG_TICKS+1) bits and never exceeds LONG_TICKS.
  - The repeat counter is clog2(REPEAT_TICKS+1) bits. No wrap-around aliasing.
- Channels are fully independent. Both keys may fire pulses in the same cycle.
- Glitches shorter than one tick that are not captured DEB_SAMPLES times in a row produce no event.
- Reset mid-operation:
  - All state clears immediately; any pulse in flight is dropped.
  - A key still held after rst deasserts is re-debounced from the all-ones state. It then yields a fresh key_press and starts a new hold count.

Decomposition:
- Shared package key_pkg:
  - Channel state enum (IDLE, PRESSED, HELD).
  - Default values of TICK_DIV, DEB_SAMPLES, LONG_TICKS, REPEAT_TICKS.
  - Active-low key polarity constant.
- Sub-module key_channel:
  - Synchronizer, debounce register, FSM and counters for one key.
  - Instantiated NKEY times.
  - Top holds the shared tick generator.

Test Plan (sim params TICK_DIV=4, DEB_SAMPLES=3, LONG_TICKS=5, REPEAT_TICKS=2):
- Reset: assert rst mid-count with key_in=2'b11 → all outputs 0, tick resumes 4 cycles after release, no events.
- Bounce: key_in[0] toggles every 3 cycles for 40 cycles, then held low → exactly one key_press[0] once 3 consecutive ticks sample 0; key_down[0] stays 1; no extra pulses.
- Short press: key_in[0] low for 4 ticks, then high → one key_press, then after release debounce one key_short; no key_long.
- Long press with repeat: key_in[1] held low 15 ticks → key_press, key_long 5 ticks after press, key_repeat every 2 ticks after that, no key_short on release.
- Simultaneous: release decided on the 5th hold tick → key_short only, no key_long. Both keys pressed together → both key_press pulses in the same cycle.
- Reset while held: key_in[0] low in HELD, pulse rst → outputs 0, then key_press again 3 ticks later, key_long 5 ticks after that.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and defaults for the key event controller
// Contents: channel state enum, default timing parameters, key polarity.
package key_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE    = 2'd0,
        KEY_PRESSED = 2'd1,
        KEY_HELD    = 2'd2
    } key_state_t;

    localparam int TICK_DIV_DEF     = 131072;
    localparam int DEB_SAMPLES_DEF  = 3;
    localparam int LONG_TICKS_DEF   = 384;
    localparam int REPEAT_TICKS_DEF = 77;

    // Board buttons pull the line low when pressed.
    localparam logic KEY_ACTIVE_LEVEL = 1'b0;

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: synchronizer, debounce, event FSM
// Ports:
//   clk, rst     - system clock, async active-high reset
//   tick         - shared sampling strobe
//   key_raw      - raw active-low button, asynchronous
//   key_down     - debounced level (1 = pressed)
//   key_press, key_short, key_long, key_repeat - single-cycle events
module key_channel
    import key_pkg::*;
#(
    parameter int DEB_SAMPLES  = DEB_SAMPLES_DEF,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_raw,
    output logic key_down,
    output logic key_press,
    output logic key_short,
    output logic key_long,
    output logic key_repeat
);

    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);
    localparam logic [DEB_SAMPLES-1:0] SAMP_PRESSED  = {DEB_SAMPLES{KEY_ACTIVE_LEVEL}};
    localparam logic [DEB_SAMPLES-1:0] SAMP_RELEASED = {DEB_SAMPLES{~KEY_ACTIVE_LEVEL}};

    logic [1:0]             sync_q;
    logic [DEB_SAMPLES-1:0] deb_q, deb_d;
    logic                   level_q, level_d;
    key_state_t             state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [RW-1:0]          rep_q, rep_d;
    logic                   press_q, press_d;
    logic                   short_q, short_d;
    logic                   long_q, long_d;
    logic                   repeat_q, repeat_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= {2{~KEY_ACTIVE_LEVEL}};
            deb_q    <= SAMP_RELEASED;
            level_q  <= 1'b0;
            state_q  <= KEY_IDLE;
            hold_q   <= '0;
            rep_q    <= '0;
            press_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_raw};
            deb_q    <= deb_d;
            level_q  <= level_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            rep_q    <= rep_d;
            press_q  <= press_d;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    always_comb begin
        deb_d    = deb_q;
        level_d  = level_q;
        state_d  = state_q;
        hold_d   = hold_q;
        rep_d    = rep_q;
        press_d  = 1'b0;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        // The level decision uses the register contents including this
        // tick's sample, so key_down moves on the edge ending the tick.
        if (tick) begin
            deb_d = {deb_q[DEB_SAMPLES-2:0], sync_q[1]};
            if (deb_d == SAMP_PRESSED) begin
                level_d = 1'b1;
            end else if (deb_d == SAMP_RELEASED) begin
                level_d = 1'b0;
            end
        end

        case (state_q)
            KEY_IDLE: begin
                if (level_d && !level_q) begin
                    state_d = KEY_PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                end
            end
            KEY_PRESSED: begin
                // Release is checked first so it wins over a due long-press.
                if (!level_d) begin
                    state_d = KEY_IDLE;
                    short_d = 1'b1;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = KEY_HELD;
                        long_d  = 1'b1;
                        hold_d  = HOLD_MAX;
                        rep_d   = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            KEY_HELD: begin
                if (!level_d) begin
                    state_d = KEY_IDLE;
                end else if (tick) begin
                    if (rep_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = KEY_IDLE;
            end
        endcase
    end

    assign key_down   = level_q;
    assign key_press  = press_q;
    assign key_short  = short_q;
    assign key_long   = long_q;
    assign key_repeat = repeat_q;

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - debounced key event generator for NKEY buttons
// Ports:
//   clk, rst    - system clock, async active-high reset
//   key_in      - raw active-low buttons
//   key_down    - debounced levels
//   key_press, key_short, key_long, key_repeat - per-key event pulses
//   tick        - shared sampling strobe
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int NKEY         = 2,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int DEB_SAMPLES  = DEB_SAMPLES_DEF,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NKEY-1:0] key_in,
    output logic [NKEY-1:0] key_down,
    output logic [NKEY-1:0] key_press,
    output logic [NKEY-1:0] key_short,
    output logic [NKEY-1:0] key_long,
    output logic [NKEY-1:0] key_repeat,
    output logic            tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    for (genvar k = 0; k < NKEY; k++) begin : g_ch
        key_channel #(
            .DEB_SAMPLES  (DEB_SAMPLES),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .key_raw    (key_in[k]),
            .key_down   (key_down[k]),
            .key_press  (key_press[k]),
            .key_short  (key_short[k]),
            .key_long   (key_long[k]),
            .key_repeat (key_repeat[k])
        );
    end

endmodule
